// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: runs frames of xfer_len full-duplex bytes over spi_physical,
// buffering outgoing and returned bytes in TX and RX FIFOs.
module spi_xfer_ctrl #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] xfer_len,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    input  logic       rx_ready,
    input  logic       flush,
    output logic       busy,
    output logic       done,
    output logic       tx_underrun,
    output logic       rx_overflow,
    output logic       ena,
    output logic [7:0] data_in,
    input  logic       new_byte,
    input  logic [7:0] data_out,
    input  logic       system_idle
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0] state_q, state_d;
    logic [8:0] remaining_q, remaining_d;
    logic ena_q, ena_d, busy_q, busy_d, done_q, done_d;
    logic underrun_q, underrun_d, overflow_q, overflow_d;

    logic [7:0] tx_mem_q [FIFO_DEPTH];
    logic [7:0] tx_mem_d [FIFO_DEPTH];
    logic [7:0] rx_mem_q [FIFO_DEPTH];
    logic [7:0] rx_mem_d [FIFO_DEPTH];
    logic [AW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [AW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;

    logic byte_ev, clr, tx_push, tx_pop, rx_push, rx_pop;

    assign tx_ready    = (tx_cnt_q != FULL);
    assign rx_valid    = (rx_cnt_q != '0);
    assign rx_data     = rx_mem_q[rx_rd_q];
    assign data_in     = (tx_cnt_q != '0) ? tx_mem_q[tx_rd_q] : 8'h00;
    assign ena         = ena_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign tx_underrun = underrun_q;
    assign rx_overflow = overflow_q;

    always_comb begin
        byte_ev = (state_q == SHIFT) && new_byte;
        clr     = flush && (state_q == IDLE);
        tx_push = tx_valid && tx_ready;
        tx_pop  = byte_ev && (tx_cnt_q != '0);
        rx_pop  = rx_valid && rx_ready;
        // a full RX still accepts when the head leaves in the same cycle
        rx_push = byte_ev && ((rx_cnt_q != FULL) || rx_pop);

        tx_mem_d = tx_mem_q;
        rx_mem_d = rx_mem_q;
        if (tx_push) tx_mem_d[tx_wr_q] = tx_data;
        if (rx_push) rx_mem_d[rx_wr_q] = data_out;

        tx_wr_d  = tx_wr_q + AW'(tx_push);
        tx_rd_d  = tx_rd_q + AW'(tx_pop);
        tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
        rx_wr_d  = rx_wr_q + AW'(rx_push);
        rx_rd_d  = rx_rd_q + AW'(rx_pop);
        rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
        if (clr) begin
            tx_wr_d  = '0;
            tx_rd_d  = '0;
            tx_cnt_d = '0;
            rx_wr_d  = '0;
            rx_rd_d  = '0;
            rx_cnt_d = '0;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        ena_d       = ena_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        underrun_d  = underrun_q;
        overflow_d  = overflow_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    underrun_d = 1'b0;
                    overflow_d = 1'b0;
                    if (xfer_len != 8'd0) begin
                        state_d     = SHIFT;
                        remaining_d = {1'b0, xfer_len};
                        ena_d       = 1'b1;
                        busy_d      = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (new_byte) begin
                    remaining_d = remaining_q - 9'd1;
                    if (tx_cnt_q == '0) underrun_d = 1'b1;
                    if (!rx_push) overflow_d = 1'b1;
                    if (remaining_q == 9'd1) begin
                        state_d = DRAIN;
                        ena_d   = 1'b0;
                    end
                end
            end
            DRAIN: begin
                if (system_idle) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                ena_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        tx_mem_q <= tx_mem_d;
        rx_mem_q <= rx_mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            ena_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            underrun_q  <= 1'b0;
            overflow_q  <= 1'b0;
            tx_wr_q     <= '0;
            tx_rd_q     <= '0;
            tx_cnt_q    <= '0;
            rx_wr_q     <= '0;
            rx_rd_q     <= '0;
            rx_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            ena_q       <= ena_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            underrun_q  <= underrun_d;
            overflow_q  <= overflow_d;
            tx_wr_q     <= tx_wr_d;
            tx_rd_q     <= tx_rd_d;
            tx_cnt_q    <= tx_cnt_d;
            rx_wr_q     <= rx_wr_d;
            rx_rd_q     <= rx_rd_d;
            rx_cnt_q    <= rx_cnt_d;
        end
    end
endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb_spi_xfer_ctrl: table-driven frames against a loopback spi_physical model;
// every RX byte is checked against a queue filled as TX bytes are pushed.
module tb_spi_xfer_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] xfer_len = 8'd0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'd0;
    logic       tx_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready = 1'b0;
    logic       flush = 1'b0;
    logic       busy, done, tx_underrun, rx_overflow, ena;
    logic [7:0] data_in;
    logic       new_byte = 1'b0;
    logic [7:0] data_out = 8'd0;
    logic       system_idle = 1'b1;

    always #5 clk = ~clk;

    spi_xfer_ctrl #(.FIFO_DEPTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .xfer_len(xfer_len),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .flush(flush), .busy(busy), .done(done),
        .tx_underrun(tx_underrun), .rx_overflow(rx_overflow),
        .ena(ena), .data_in(data_in), .new_byte(new_byte),
        .data_out(data_out), .system_idle(system_idle)
    );

    int n_checks = 0;
    int n_pass = 0;
    logic [7:0] exp_q[$];
    int nb_cnt = 0, done_cnt = 0, ena_rises = 0, ena_falls = 0;
    bit drain_en = 1'b0, pop_on_nb = 1'b0, ena_prev = 1'b0;
    int phy_period = 80, phy_tail = 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // loopback phy: sample data_in when a byte starts, return it on new_byte
    int p_st = 0, p_cnt = 0;
    logic [7:0] p_byte = 8'd0;
    always @(posedge clk) begin
        new_byte <= 1'b0;
        if (rst) begin
            p_st <= 0;
            system_idle <= 1'b1;
        end else begin
            case (p_st)
                0: if (ena) begin
                    p_st <= 1; p_byte <= data_in;
                    p_cnt <= phy_period - 1; system_idle <= 1'b0;
                end
                1: if (p_cnt == 0) begin
                    new_byte <= 1'b1; data_out <= p_byte; p_st <= 2;
                end else p_cnt <= p_cnt - 1;
                2: p_st <= 4;
                4: if (ena) begin
                    p_st <= 1; p_byte <= data_in; p_cnt <= phy_period - 1;
                end else begin
                    p_st <= 3; p_cnt <= phy_tail;
                end
                3: if (p_cnt == 0) begin
                    p_st <= 0; system_idle <= 1'b1;
                end else p_cnt <= p_cnt - 1;
                default: p_st <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        rx_ready = drain_en || (pop_on_nb && new_byte);
        if (new_byte) nb_cnt++;
        if (done) done_cnt++;
        if (ena && !ena_prev) ena_rises++;
        if (!ena && ena_prev) ena_falls++;
        ena_prev = ena;
        if (!rst && rx_valid && rx_ready) begin
            if (exp_q.size() == 0) chk("rx_extra_byte", int'(rx_data), -1);
            else chk("rx_byte", int'(rx_data), int'(exp_q.pop_front()));
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_tx(input logic [7:0] b, input bit expect_rx);
        bit ok = 1'b0;
        tx_data = b;
        tx_valid = 1'b1;
        for (int t = 0; t < 20000 && !ok; t++) begin
            if (tx_ready) begin
                ok = 1'b1;
                if (expect_rx) exp_q.push_back(b);
            end
            @(negedge clk);
        end
        tx_valid = 1'b0;
        if (!ok) chk("tx_push_timeout", 0, 1);
    endtask

    task automatic pulse_start(input logic [7:0] len);
        start = 1'b1;
        xfer_len = len;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int t = 0;
        while (!done && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk(name, done, 1);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_ena"}, ena, 0);
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        tick(2);
        chk(name, exp_q.size(), 0);
        chk({name, "_rx_valid"}, rx_valid, 0);
    endtask

    typedef struct {
        int period;
        int tail;
        int npush;
        int len;
        int exp_nb;
        bit exp_und;
        bit exp_ovf;
    } vec_t;

    vec_t vecs[9];
    logic [7:0] data_tab[4];

    initial begin
        vec_t v;
        int nb0, d0, r0, f0, t;
        data_tab[0] = 8'hA5; data_tab[1] = 8'h3C;
        data_tab[2] = 8'h01; data_tab[3] = 8'hFF;
        for (int m = 0; m < 4; m++) begin
            vecs[m]     = '{16 * 5,   m + 1, 4, 4, 4, 1'b0, 1'b0};
            vecs[m + 4] = '{16 * 100, m + 1, 4, 4, 4, 1'b0, 1'b0};
        end
        vecs[8] = '{40, 2, 2, 3, 3, 1'b1, 1'b0};

        tick(3);
        rst = 1'b0;
        chk("rst_ena", ena, 0);
        chk("rst_data_in", data_in, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_underrun", tx_underrun, 0);
        chk("rst_overflow", rx_overflow, 0);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_rx_valid", rx_valid, 0);

        push_tx(8'hEE, 1'b0);
        chk("tx_head_visible", data_in, 8'hEE);
        push_tx(8'hDD, 1'b0);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        chk("flush_tx_empty", data_in, 0);

        drain_en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            v = vecs[i];
            phy_period = v.period;
            phy_tail = v.tail;
            for (int k = 0; k < v.npush; k++) push_tx(data_tab[k], 1'b1);
            for (int k = v.npush; k < v.len; k++) exp_q.push_back(8'h00);
            nb0 = nb_cnt;
            d0 = done_cnt;
            pulse_start(v.len[7:0]);
            chk("busy_after_start", busy, 1);
            chk("ena_after_start", ena, 1);
            if (v.exp_und) begin
                tick(5);
                pulse_start(8'd9);
            end
            wait_done(v.len * (v.period + 4) + 200, "frame_done");
            tick(2);
            chk("frame_new_bytes", nb_cnt - nb0, v.exp_nb);
            chk("frame_done_count", done_cnt - d0, 1);
            chk("frame_underrun", tx_underrun, v.exp_und);
            chk("frame_overflow", rx_overflow, v.exp_ovf);
            wait_drain("frame_drain");
        end

        d0 = done_cnt;
        r0 = ena_rises;
        pulse_start(8'd0);
        chk("len0_done", done, 1);
        chk("len0_busy", busy, 0);
        chk("len0_underrun_cleared", tx_underrun, 0);
        tick(1);
        chk("len0_done_single", done, 0);
        tick(3);
        chk("len0_no_ena", ena_rises - r0, 0);
        chk("len0_done_count", done_cnt - d0, 1);

        drain_en = 1'b0;
        tick(2);
        for (int k = 0; k < 16; k++) push_tx(8'h10 + 8'(k), 1'b1);
        chk("tx_full_ready", tx_ready, 0);
        tx_data = 8'h77;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        chk("tx_full_hold", tx_ready, 0);
        phy_period = 20;
        phy_tail = 1;
        nb0 = nb_cnt;
        pulse_start(8'd20);
        wait_done(20 * 30 + 200, "ovf_done");
        tick(2);
        chk("ovf_new_bytes", nb_cnt - nb0, 20);
        chk("ovf_flag", rx_overflow, 1);
        chk("ovf_underrun", tx_underrun, 1);
        chk("ovf_rx_valid", rx_valid, 1);

        push_tx(8'h5A, 1'b1);
        pop_on_nb = 1'b1;
        pulse_start(8'd1);
        wait_done(200, "fullpp_done");
        tick(2);
        pop_on_nb = 1'b0;
        chk("fullpp_no_overflow", rx_overflow, 0);
        chk("fullpp_no_underrun", tx_underrun, 0);
        chk("fullpp_queue_depth", exp_q.size(), 16);
        drain_en = 1'b1;
        wait_drain("fullpp_drain");

        drain_en = 1'b0;
        tick(2);
        phy_period = 40;
        for (int k = 0; k < 16; k++) push_tx(8'(k * 17 + 1), 1'b1);
        nb0 = nb_cnt;
        pulse_start(8'd10);
        t = 0;
        while (nb_cnt - nb0 < 2 && t < 1000) begin
            tick(1);
            t++;
        end
        tick(10);
        chk("mid_rx_before_rst", rx_valid, 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        exp_q.delete();
        chk("mid_rst_ena", ena, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_tx_ready", tx_ready, 1);
        chk("mid_rst_tx_empty", data_in, 0);
        chk("mid_rst_rx_valid", rx_valid, 0);
        chk("mid_rst_underrun", tx_underrun, 0);
        chk("mid_rst_overflow", rx_overflow, 0);
        drain_en = 1'b1;
        push_tx(8'hC3, 1'b1);
        push_tx(8'h96, 1'b1);
        nb0 = nb_cnt;
        d0 = done_cnt;
        pulse_start(8'd2);
        wait_done(400, "post_rst_done");
        tick(2);
        chk("post_rst_new_bytes", nb_cnt - nb0, 2);
        chk("post_rst_done_count", done_cnt - d0, 1);
        wait_drain("post_rst_drain");

        phy_period = 20;
        nb0 = nb_cnt;
        d0 = done_cnt;
        f0 = ena_falls;
        fork
            for (int k = 0; k < 255; k++) push_tx(8'(k * 7 + 3), 1'b1);
            begin
                tick(20);
                pulse_start(8'd255);
                wait_done(255 * 40, "stream_done");
            end
        join
        tick(2);
        chk("stream_new_bytes", nb_cnt - nb0, 255);
        chk("stream_done_count", done_cnt - d0, 1);
        chk("stream_underrun", tx_underrun, 0);
        chk("stream_overflow", rx_overflow, 0);
        chk("stream_ena_falls", ena_falls - f0, 1);
        wait_drain("stream_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
